// File: rtl/display_collector_if.sv
// Result-display stream, readout port and status flags between the display
// sequencer / board readout (master) and the collector (slave).
interface display_collector_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] disp_data_i;
    logic [2:0]        disp_state_i;
    logic              clear_i;
    logic [3:0]        rd_addr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              busy_o;
    logic              done_o;
    logic              match_o;
    logic [7:0]        mismatch_mask_o;
    logic              err_o;
    logic [7:0]        frame_cnt_o;

    modport master (
        output disp_data_i, disp_state_i, clear_i, rd_addr_i,
        input  rd_data_o, busy_o, done_o, match_o, mismatch_mask_o, err_o, frame_cnt_o
    );

    modport slave (
        input  disp_data_i, disp_state_i, clear_i, rd_addr_i,
        output rd_data_o, busy_o, done_o, match_o, mismatch_mask_o, err_o, frame_cnt_o
    );
endinterface

// File: rtl/display_collector.sv
// Reassembles the PE / 3x3 / 2x2 result groups into a 12-entry register file
// and cross-checks both alternate paths element-wise against the PE result.
module display_collector #(
    parameter int DATA_W = 8,
    parameter int N_ELEM = 4
) (
    input logic               clk,
    input logic               reset,
    display_collector_if.slave bus
);
    localparam int                DEPTH    = 3 * N_ELEM;
    localparam int                PTR_W    = 4;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  GRP_SIZE = PTR_W'(N_ELEM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic                    done_q, done_d;
    logic                    match_q, match_d;
    logic [2*N_ELEM-1:0]     mask_q, mask_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    wr_en;
    logic                    clr_mem;
    logic [PTR_W-1:0]        wr_addr;
    logic [2:0]              exp_code;
    logic [2*N_ELEM-1:0]     cmp_mask;

    // Group code the byte at wptr must carry: 1 for PE, 2 for 3x3, 3 for 2x2.
    assign exp_code = 3'(wptr_q / GRP_SIZE) + 3'd1;

    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_cmp
        assign cmp_mask[gi]          = mem_q[N_ELEM + gi]   != mem_q[gi];
        assign cmp_mask[N_ELEM + gi] = mem_q[2*N_ELEM + gi] != mem_q[gi];
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        done_d  = done_q;
        match_d = match_q;
        mask_d  = mask_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        clr_mem = 1'b0;
        wr_addr = wptr_q;

        if (bus.clear_i) begin
            state_d = S_IDLE;
            wptr_d  = '0;
            done_d  = 1'b0;
            match_d = 1'b0;
            mask_d  = '0;
            err_d   = 1'b0;
            clr_mem = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.disp_state_i == 3'd1) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        wptr_d  = PTR_W'(1);
                        state_d = S_RECV;
                    end else if (bus.disp_state_i != 3'd0) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_RECV: begin
                    if (wptr_q < LAST_PTR && bus.disp_state_i == exp_code) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + PTR_W'(1);
                    end else if (wptr_q == LAST_PTR && bus.disp_state_i == 3'd4) begin
                        state_d = S_CHECK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_CHECK: begin
                    // A new frame may only start once the check has been published.
                    if (bus.disp_state_i == 3'd0 || bus.disp_state_i == 3'd4) begin
                        mask_d  = cmp_mask;
                        match_d = (cmp_mask == '0);
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_DONE: begin
                    if (bus.disp_state_i == 3'd1) begin
                        done_d  = 1'b0;
                        match_d = 1'b0;
                        mask_d  = '0;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        wptr_d  = PTR_W'(1);
                        state_d = S_RECV;
                    end else if (bus.disp_state_i != 3'd0 && bus.disp_state_i != 3'd4) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            done_q  <= done_d;
            match_q <= match_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_mem) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= bus.disp_data_i;
        end
    end

    assign bus.rd_data_o       = (bus.rd_addr_i < LAST_PTR) ? mem_q[bus.rd_addr_i] : '0;
    assign bus.busy_o          = (state_q == S_RECV) || (state_q == S_CHECK);
    assign bus.done_o          = done_q;
    assign bus.match_o         = match_q;
    assign bus.mismatch_mask_o = mask_q;
    assign bus.err_o           = err_q;
    assign bus.frame_cnt_o     = cnt_q;
endmodule
